// File: rtl/core_run_ctrl.sv
// Run-control for the MIPS datapath clock enable: N-cycle runs, single steps and
// free runs that stop on a halt command, a core halt request or a PC breakpoint.
module core_run_ctrl #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32,
  parameter int CYC_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             halt_req,
  input  logic [PC_W-1:0]  core_pc,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stop_cause,
  output logic             cmd_err,
  output logic [CYC_W-1:0] run_cycles,
  output logic [CYC_W-1:0] total_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_RUN_N = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_FREE  = 2'd2;
  localparam logic [1:0] OP_HALT  = 2'd3;

  localparam logic [2:0] CAUSE_COUNT    = 3'd0;
  localparam logic [2:0] CAUSE_HALT_CMD = 3'd1;
  localparam logic [2:0] CAUSE_HALT_REQ = 3'd2;
  localparam logic [2:0] CAUSE_BP       = 3'd3;
  localparam logic [2:0] CAUSE_ZERO     = 3'd4;

  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};

  state_t           state_r;
  logic [CNT_W-1:0] remaining_r;
  logic             first_r;
  logic             bounded_r;

  logic             accept_s;
  logic             halt_cmd_s;
  logic             bp_hit_s;
  logic             count_end_s;
  logic             stop_s;
  logic [2:0]       cause_s;

  assign cmd_ready = (state_r == ST_IDLE) | (state_r == ST_RUN);
  assign busy      = (state_r == ST_RUN);
  assign core_en   = busy & ~stop_s;

  // Stop detection; the first-cycle mask lets a run resume from the breakpoint PC.
  always_comb begin
    accept_s    = cmd_valid & cmd_ready;
    halt_cmd_s  = accept_s & (cmd_op == OP_HALT);
    bp_hit_s    = bp_en & (core_pc == bp_addr) & ~first_r;
    count_end_s = bounded_r & (remaining_r == {CNT_W{1'b0}});
    stop_s      = busy & (halt_cmd_s | halt_req | bp_hit_s | count_end_s);
    if (halt_cmd_s) begin
      cause_s = CAUSE_HALT_CMD;
    end else if (halt_req) begin
      cause_s = CAUSE_HALT_REQ;
    end else if (bp_hit_s) begin
      cause_s = CAUSE_BP;
    end else begin
      cause_s = CAUSE_COUNT;
    end
  end

  // Run-control state machine, pulses and saturating cycle counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      remaining_r  <= {CNT_W{1'b0}};
      first_r      <= 1'b0;
      bounded_r    <= 1'b0;
      done         <= 1'b0;
      cmd_err      <= 1'b0;
      stop_cause   <= 3'd0;
      run_cycles   <= {CYC_W{1'b0}};
      total_cycles <= {CYC_W{1'b0}};
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      if (core_en) begin
        remaining_r <= remaining_r - CNT_W'(1);
        first_r     <= 1'b0;
        if (run_cycles != CYC_MAX) run_cycles <= run_cycles + CYC_W'(1);
        if (total_cycles != CYC_MAX) total_cycles <= total_cycles + CYC_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (cmd_op)
              OP_RUN_N, OP_STEP: begin
                run_cycles  <= {CYC_W{1'b0}};
                first_r     <= 1'b1;
                bounded_r   <= 1'b1;
                remaining_r <= (cmd_op == OP_STEP) ? CNT_W'(1) : cmd_count;
                if ((cmd_op == OP_RUN_N) && (cmd_count == {CNT_W{1'b0}})) begin
                  state_r    <= ST_DONE;
                  done       <= 1'b1;
                  stop_cause <= CAUSE_ZERO;
                end else begin
                  state_r <= ST_RUN;
                end
              end
              OP_FREE: begin
                run_cycles <= {CYC_W{1'b0}};
                first_r    <= 1'b1;
                bounded_r  <= 1'b0;
                state_r    <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (accept_s && !halt_cmd_s) cmd_err <= 1'b1;
          if (stop_s) begin
            state_r    <= ST_DONE;
            done       <= 1'b1;
            stop_cause <= cause_s;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized bench for core_run_ctrl: each run is planned as per-cycle stimulus,
// and the stop cycle, cause and error count are predicted from that plan.
module tb_core_run_ctrl;
  localparam int CNT_W = 16;
  localparam int PC_W  = 32;
  localparam int CYC_W = 32;
  localparam int N     = 80;

  logic             clock     = 1'b0;
  logic             reset_n   = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op    = 2'd0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             halt_req  = 1'b0;
  logic [PC_W-1:0]  core_pc   = '0;
  logic             bp_en     = 1'b0;
  logic [PC_W-1:0]  bp_addr   = '0;
  logic             core_en, busy, done, cmd_err;
  logic [2:0]       stop_cause;
  logic [CYC_W-1:0] run_cycles, total_cycles;

  logic       s_valid = 1'b0;
  logic [1:0] s_op    = 2'd0;
  logic       s_ready, s_en, s_busy, s_done, s_err;
  logic [2:0] s_cause;
  logic [3:0] s_run, s_tot;

  always #5 clock = ~clock;

  core_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .CYC_W(CYC_W)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .halt_req(halt_req), .core_pc(core_pc),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_en(core_en), .busy(busy), .done(done),
    .stop_cause(stop_cause), .cmd_err(cmd_err), .run_cycles(run_cycles),
    .total_cycles(total_cycles)
  );

  core_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .CYC_W(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_op(s_op), .cmd_count(16'd0), .halt_req(1'b0), .core_pc(32'd0),
    .bp_en(1'b0), .bp_addr(32'd0), .core_en(s_en), .busy(s_busy), .done(s_done),
    .stop_cause(s_cause), .cmd_err(s_err), .run_cycles(s_run), .total_cycles(s_tot)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic       p_hreq[N];
  logic       p_cv[N];
  logic [1:0] p_op[N];
  int         s_exp, cause_exp, err_exp;
  longint     tot_exp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Quiet plan with a HALT command at the last slot as a backstop for free runs.
  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      p_hreq[i] = 1'b0;
      p_cv[i]   = 1'b0;
      p_op[i]   = 2'd0;
    end
    p_cv[N-1] = 1'b1;
    p_op[N-1] = 2'd3;
  endtask

  task automatic random_plan();
    for (int i = 0; i < N; i++) begin
      p_hreq[i] = ($urandom_range(0, 29) == 0);
      p_cv[i]   = ($urandom_range(0, 9) == 0);
      p_op[i]   = 2'($urandom_range(0, 3));
    end
    p_cv[N-1] = 1'b1;
    p_op[N-1] = 2'd3;
  endtask

  // While running every cycle is enabled, so the PC in run cycle i is pc0 + 4*i.
  task automatic predict(input bit bounded, input int cnt, input logic [PC_W-1:0] pc0);
    s_exp = N;
    cause_exp = 0;
    for (int i = 0; i < N; i++) begin
      logic [PC_W-1:0] pc_i;
      pc_i = pc0 + PC_W'(4 * i);
      if (p_cv[i] && p_op[i] == 2'd3) cause_exp = 1;
      else if (p_hreq[i]) cause_exp = 2;
      else if (bp_en && pc_i == bp_addr && i > 0) cause_exp = 3;
      else if (bounded && i == cnt) cause_exp = 0;
      else continue;
      s_exp = i;
      break;
    end
    err_exp = 0;
    for (int i = 0; i <= s_exp && i < N; i++)
      if (p_cv[i] && p_op[i] != 2'd3) err_exp++;
  endtask

  task automatic do_run(input logic [1:0] op, input int count);
    bit bounded;
    int cnt, en_seen, done_seen, err_seen;
    logic en_prev;
    bounded = (op != 2'd2);
    cnt = (op == 2'd1) ? 1 : count;
    predict(bounded, cnt, core_pc);
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_count = CNT_W'(count); halt_req = 1'b0;
    @(negedge clock);
    check_eq("ready_idle", 64'(cmd_ready), 64'd1);
    check_eq("en_idle", 64'(core_en), 64'd0);
    @(posedge clock); #1;
    cmd_valid = 1'b0; cmd_op = 2'd0;
    if (bounded && cnt == 0) begin
      @(negedge clock);
      check_eq("zero_done", 64'(done), 64'd1);
      check_eq("zero_cause", 64'(stop_cause), 64'd4);
      check_eq("zero_en", 64'(core_en), 64'd0);
      check_eq("zero_ready", 64'(cmd_ready), 64'd0);
      check_eq("zero_run_cycles", 64'(run_cycles), 64'd0);
    end else begin
      en_seen = 0; done_seen = 0; err_seen = 0; en_prev = 1'b0;
      for (int i = 0; i <= s_exp && i < N; i++) begin
        if (i > 0) begin @(posedge clock); #1; end
        if (en_prev) core_pc = core_pc + 32'd4;
        cmd_valid = p_cv[i]; cmd_op = p_op[i]; cmd_count = CNT_W'($urandom);
        halt_req = p_hreq[i];
        @(negedge clock);
        check_eq("core_en", 64'(core_en), 64'(i < s_exp));
        en_prev = core_en;
        en_seen += int'(core_en);
        done_seen += int'(done);
        err_seen += int'(cmd_err);
      end
      @(posedge clock); #1;
      cmd_valid = 1'b0; halt_req = 1'b0;
      tot_exp += s_exp;
      @(negedge clock);
      err_seen += int'(cmd_err);
      check_eq("done_pulse", 64'(done), 64'd1);
      check_eq("early_done", 64'(done_seen), 64'd0);
      check_eq("stop_cause", 64'(stop_cause), 64'(cause_exp));
      check_eq("en_in_done", 64'(core_en), 64'd0);
      check_eq("enable_count", 64'(en_seen), 64'(s_exp));
      check_eq("cmd_err_count", 64'(err_seen), 64'(err_exp));
      check_eq("run_cycles", 64'(run_cycles), 64'(s_exp));
      check_eq("total_cycles", 64'(total_cycles), 64'(tot_exp));
    end
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("idle_done", 64'(done), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int en_cnt, done_cnt;
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_core_en", 64'(core_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_cmd_err", 64'(cmd_err), 64'd0);
    check_eq("rst_cause", 64'(stop_cause), 64'd0);
    check_eq("rst_run", 64'(run_cycles), 64'd0);
    check_eq("rst_total", 64'(total_cycles), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Free run aborted by reset after five enables.
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd2;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    en_cnt = 0;
    repeat (5) begin
      @(negedge clock);
      en_cnt += int'(core_en);
      @(posedge clock); #1;
    end
    check_eq("abort_enables", 64'(en_cnt), 64'd5);
    reset_n = 1'b0;
    #1;
    check_eq("abort_core_en", 64'(core_en), 64'd0);
    check_eq("abort_run", 64'(run_cycles), 64'd0);
    check_eq("abort_total", 64'(total_cycles), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    done_cnt = 0;
    repeat (2) begin @(negedge clock); done_cnt += int'(done); end
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (4) begin @(negedge clock); done_cnt += int'(done); end
    check_eq("abort_no_done", 64'(done_cnt), 64'd0);

    // HALT while idle is a no-op.
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_op = 2'd3;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    check_eq("idle_halt_done", 64'(done), 64'd0);
    check_eq("idle_halt_err", 64'(cmd_err), 64'd0);
    check_eq("idle_halt_busy", 64'(busy), 64'd0);

    clear_plan(); do_run(2'd0, 9);
    clear_plan(); do_run(2'd0, 0);
    repeat (3) begin clear_plan(); do_run(2'd1, 0); end

    core_pc = '0; bp_en = 1'b1; bp_addr = 32'h20;
    clear_plan(); do_run(2'd2, 0);
    check_eq("bp_pc", 64'(core_pc), 64'h20);
    clear_plan(); do_run(2'd1, 0);
    bp_en = 1'b0;

    clear_plan(); p_cv[5] = 1'b1; p_op[5] = 2'd3; p_hreq[5] = 1'b1; do_run(2'd2, 0);
    clear_plan(); p_hreq[3] = 1'b1; do_run(2'd2, 0);
    clear_plan(); p_cv[10] = 1'b1; p_op[10] = 2'd0; do_run(2'd0, 50);

    for (int r = 0; r < 40; r++) begin
      int cnt;
      random_plan();
      bp_en = ($urandom_range(0, 1) == 1);
      bp_addr = core_pc + PC_W'(4 * $urandom_range(0, 30));
      cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      do_run(2'($urandom_range(0, 2)), cnt);
    end
    bp_en = 1'b0;

    // Narrow counters saturate at 15.
    @(posedge clock); #1;
    s_valid = 1'b1; s_op = 2'd2;
    @(posedge clock); #1;
    s_valid = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    s_valid = 1'b1; s_op = 2'd3;
    @(negedge clock);
    check_eq("sat_en_stop", 64'(s_en), 64'd0);
    @(posedge clock); #1;
    s_valid = 1'b0;
    @(negedge clock);
    check_eq("sat_done", 64'(s_done), 64'd1);
    check_eq("sat_cause", 64'(s_cause), 64'd1);
    check_eq("sat_run", 64'(s_run), 64'd15);
    check_eq("sat_total", 64'(s_tot), 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
